// File: rtl/buffer_ex_mem.sv
// EX/MEM pipeline register: captures EX results, forwards M/WB controls, supports stall/flush/valid.
// Optional performance counters (bubble_cnt, branch_taken_cnt) enabled by defining EXMEM_PERF_CNT_EN.
module buffer_ex_mem #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              stall,
    input  logic              flush,
    input  logic [2:0]        M,
    input  logic [1:0]        WB,
    input  logic [DATA_W-1:0] add_result,
    input  logic              zero,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] rd2,
    input  logic [REG_W-1:0]  write_reg,
    output logic              valid_q,
    output logic              MemWrite_q,
    output logic              MemRead_q,
    output logic              Branch_q,
    output logic              MemtoReg_q,
    output logic              RegWrite_q,
    output logic [DATA_W-1:0] branch_target_q,
    output logic              zero_q,
    output logic [DATA_W-1:0] alu_result_q,
    output logic [DATA_W-1:0] write_data_q,
    output logic [REG_W-1:0]  write_reg_q,
`ifdef EXMEM_PERF_CNT_EN
    output logic [CNT_W-1:0]  bubble_cnt,
    output logic [CNT_W-1:0]  branch_taken_cnt,
`endif
    output logic              pcsrc
);

    logic [2:0] m_q;
    logic [1:0] wb_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q         <= 1'b0;
            m_q             <= '0;
            wb_q            <= '0;
            branch_target_q <= '0;
            zero_q          <= 1'b0;
            alu_result_q    <= '0;
            write_data_q    <= '0;
            write_reg_q     <= '0;
        end else if (flush) begin
            // Bubble: kill controls only; data fields keep their last values.
            valid_q <= 1'b0;
            m_q     <= '0;
            wb_q    <= '0;
        end else if (!stall) begin
            valid_q         <= in_valid;
            m_q             <= in_valid ? M  : 3'b000;
            wb_q            <= in_valid ? WB : 2'b00;
            branch_target_q <= add_result;
            zero_q          <= zero;
            alu_result_q    <= alu_result;
            write_data_q    <= rd2;
            write_reg_q     <= write_reg;
        end
    end

    assign MemWrite_q = valid_q & m_q[2];
    assign MemRead_q  = valid_q & m_q[1];
    assign Branch_q   = valid_q & m_q[0];
    assign MemtoReg_q = valid_q & wb_q[1];
    assign RegWrite_q = valid_q & wb_q[0];
    assign pcsrc      = valid_q & Branch_q & zero_q;

`ifdef EXMEM_PERF_CNT_EN
    // A flush loads a bubble even when stall is also high, so it always counts.
    logic bubble_load;
    assign bubble_load = flush | (!stall & !in_valid);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bubble_cnt       <= '0;
            branch_taken_cnt <= '0;
        end else begin
            if (bubble_load)
                bubble_cnt <= bubble_cnt + 1'b1;
            if (pcsrc && !stall)
                branch_taken_cnt <= branch_taken_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_buffer_ex_mem.sv
// Self-checking bench for buffer_ex_mem: directed vector table plus reset and counter sequences.
module tb_buffer_ex_mem;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, stall, flush, zero;
    logic [2:0]  M;
    logic [1:0]  WB;
    logic [31:0] add_result, alu_result, rd2;
    logic [4:0]  write_reg;
    logic        valid_q, MemWrite_q, MemRead_q, Branch_q, MemtoReg_q, RegWrite_q;
    logic        zero_q, pcsrc;
    logic [31:0] branch_target_q, alu_result_q, write_data_q;
    logic [4:0]  write_reg_q;
`ifdef EXMEM_PERF_CNT_EN
    logic [31:0] bubble_cnt, branch_taken_cnt;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    buffer_ex_mem dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .stall(stall), .flush(flush),
        .M(M), .WB(WB), .add_result(add_result), .zero(zero),
        .alu_result(alu_result), .rd2(rd2), .write_reg(write_reg),
        .valid_q(valid_q), .MemWrite_q(MemWrite_q), .MemRead_q(MemRead_q),
        .Branch_q(Branch_q), .MemtoReg_q(MemtoReg_q), .RegWrite_q(RegWrite_q),
        .branch_target_q(branch_target_q), .zero_q(zero_q),
        .alu_result_q(alu_result_q), .write_data_q(write_data_q),
        .write_reg_q(write_reg_q),
`ifdef EXMEM_PERF_CNT_EN
        .bubble_cnt(bubble_cnt), .branch_taken_cnt(branch_taken_cnt),
`endif
        .pcsrc(pcsrc)
    );

    typedef struct {
        logic        v, st, fl, z;
        logic [2:0]  m;
        logic [1:0]  wb;
        logic [31:0] add, alu, d2;
        logic [4:0]  wr;
        // expected
        logic        e_valid, e_mw, e_mr, e_br, e_m2r, e_rw, e_z, e_pc;
        logic [31:0] e_bt, e_alu, e_wd;
        logic [4:0]  e_wr;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, st, fl, z, input logic [2:0] m, input logic [1:0] wb,
                         input logic [31:0] add, alu, d2, input logic [4:0] wr);
        in_valid = v; stall = st; flush = fl; zero = z; M = m; WB = wb;
        add_result = add; alu_result = alu; rd2 = d2; write_reg = wr;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic v, st, fl, z, input logic [2:0] m, input logic [1:0] wb,
                                input logic [31:0] add, alu, d2, input logic [4:0] wr,
                                input logic ev, emw, emr, ebr, em2r, erw, ez, epc,
                                input logic [31:0] ebt, ealu, ewd, input logic [4:0] ewr);
        vec_t r;
        r.v = v; r.st = st; r.fl = fl; r.z = z; r.m = m; r.wb = wb;
        r.add = add; r.alu = alu; r.d2 = d2; r.wr = wr;
        r.e_valid = ev; r.e_mw = emw; r.e_mr = emr; r.e_br = ebr; r.e_m2r = em2r;
        r.e_rw = erw; r.e_z = ez; r.e_pc = epc;
        r.e_bt = ebt; r.e_alu = ealu; r.e_wd = ewd; r.e_wr = ewr;
        return r;
    endfunction

    task automatic do_reset();
        drive(0, 0, 0, 0, 3'b000, 2'b00, 0, 0, 0, 0);
        #2 rst = 1'b1;
        #10 rst = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        drive(0, 0, 0, 0, 3'b000, 2'b00, 0, 0, 0, 0);
        do_reset();
        step();
        check("reset_valid", valid_q, 0);
        check("reset_alu", alu_result_q, 0);

        // Reset asserted between edges must clear outputs without a clock edge.
        drive(1, 0, 0, 0, 3'b001, 2'b11, 32'h0, 32'h0000_00A4, 32'h0, 5'd1);
        step();
        check("pre_rst_alu", alu_result_q, 32'h0000_00A4);
        check("pre_rst_rw", RegWrite_q, 1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_valid", valid_q, 0);
        check("async_rst_rw", RegWrite_q, 0);
        check("async_rst_m2r", MemtoReg_q, 0);
        check("async_rst_alu", alu_result_q, 0);
        check("async_rst_wr", write_reg_q, 0);
        check("async_rst_pcsrc", pcsrc, 0);
        drive(0, 0, 0, 0, 3'b000, 2'b00, 0, 0, 0, 0);
        #1 rst = 1'b0;
        step();

        // Sequential vector table; expectations follow from the previous row's state.
        vecs[0]  = mk(1,0,0,0, 3'b010, 2'b11, 32'h0, 32'h1000_0008, 32'hDEAD_BEEF, 5'd9,
                      1,0,1,0,1,1,0,0, 32'h0, 32'h1000_0008, 32'hDEAD_BEEF, 5'd9);
        vecs[1]  = mk(1,0,0,1, 3'b001, 2'b00, 32'h0040_0020, 32'h0, 32'h0, 5'd0,
                      1,0,0,1,0,0,1,1, 32'h0040_0020, 32'h0, 32'h0, 5'd0);
        vecs[2]  = mk(1,0,1,0, 3'b111, 2'b11, 32'hFFFF_FFFF, 32'h1234_5678, 32'h1, 5'd4,
                      0,0,0,0,0,0,1,0, 32'h0040_0020, 32'h0, 32'h0, 5'd0);
        vecs[3]  = mk(1,0,0,0, 3'b000, 2'b01, 32'h77, 32'h55, 32'h66, 5'd3,
                      1,0,0,0,0,1,0,0, 32'h77, 32'h55, 32'h66, 5'd3);
        vecs[4]  = mk(0,1,0,1, 3'b111, 2'b10, 32'hA1, 32'hA2, 32'hA3, 5'd10,
                      1,0,0,0,0,1,0,0, 32'h77, 32'h55, 32'h66, 5'd3);
        vecs[5]  = mk(1,1,0,1, 3'b101, 2'b11, 32'hB1, 32'hB2, 32'hB3, 5'd11,
                      1,0,0,0,0,1,0,0, 32'h77, 32'h55, 32'h66, 5'd3);
        vecs[6]  = mk(1,1,0,0, 3'b011, 2'b00, 32'hC1, 32'hC2, 32'hC3, 5'd12,
                      1,0,0,0,0,1,0,0, 32'h77, 32'h55, 32'h66, 5'd3);
        vecs[7]  = mk(1,1,1,1, 3'b111, 2'b11, 32'hD1, 32'hD2, 32'hD3, 5'd13,
                      0,0,0,0,0,0,0,0, 32'h77, 32'h55, 32'h66, 5'd3);
        vecs[8]  = mk(0,0,0,1, 3'b100, 2'b01, 32'h99, 32'h44, 32'h88, 5'd7,
                      0,0,0,0,0,0,1,0, 32'h99, 32'h44, 32'h88, 5'd7);
        vecs[9]  = mk(1,0,0,1, 3'b101, 2'b00, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd31,
                      1,1,0,1,0,0,1,1, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd31);
        vecs[10] = mk(1,0,0,0, 3'b001, 2'b10, 32'h10, 32'h20, 32'h30, 5'd1,
                      1,0,0,1,1,0,0,0, 32'h10, 32'h20, 32'h30, 5'd1);

        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].v, vecs[i].st, vecs[i].fl, vecs[i].z, vecs[i].m, vecs[i].wb,
                  vecs[i].add, vecs[i].alu, vecs[i].d2, vecs[i].wr);
            step();
            check($sformatf("v%0d_valid", i), valid_q, vecs[i].e_valid);
            check($sformatf("v%0d_memwrite", i), MemWrite_q, vecs[i].e_mw);
            check($sformatf("v%0d_memread", i), MemRead_q, vecs[i].e_mr);
            check($sformatf("v%0d_branch", i), Branch_q, vecs[i].e_br);
            check($sformatf("v%0d_memtoreg", i), MemtoReg_q, vecs[i].e_m2r);
            check($sformatf("v%0d_regwrite", i), RegWrite_q, vecs[i].e_rw);
            check($sformatf("v%0d_zero", i), zero_q, vecs[i].e_z);
            check($sformatf("v%0d_pcsrc", i), pcsrc, vecs[i].e_pc);
            check($sformatf("v%0d_target", i), branch_target_q, vecs[i].e_bt);
            check($sformatf("v%0d_alu", i), alu_result_q, vecs[i].e_alu);
            check($sformatf("v%0d_wdata", i), write_data_q, vecs[i].e_wd);
            check($sformatf("v%0d_wreg", i), write_reg_q, vecs[i].e_wr);
        end

        // Deasserting reset between edges: nothing captured until the next rising edge.
        drive(1, 0, 0, 0, 3'b000, 2'b01, 32'h0, 32'hCAFE, 32'h0, 5'd2);
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        #1;
        check("rst_release_hold", alu_result_q, 0);
        step();
        check("rst_release_capture", alu_result_q, 32'hCAFE);
        check("rst_release_valid", valid_q, 1);

`ifdef EXMEM_PERF_CNT_EN
        do_reset();
        #1;
        check("cnt_reset_bubble", bubble_cnt, 0);
        check("cnt_reset_branch", branch_taken_cnt, 0);
        drive(1, 0, 1, 0, 3'b000, 2'b00, 0, 0, 0, 0); step();        // flush 1
        drive(1, 0, 1, 0, 3'b000, 2'b00, 0, 0, 0, 0); step();        // flush 2
        drive(0, 0, 0, 0, 3'b000, 2'b00, 0, 0, 0, 0); step();        // in_valid=0
        drive(1, 0, 0, 1, 3'b001, 2'b00, 32'h40, 0, 0, 0); step();   // taken branch loaded
        check("cnt_pcsrc_up", pcsrc, 1);
        drive(1, 0, 0, 0, 3'b000, 2'b00, 0, 0, 0, 0); step();        // pcsrc counted here
        drive(0, 1, 0, 0, 3'b000, 2'b00, 0, 0, 0, 0); step();        // stalled, no bubble
        check("cnt_bubble", bubble_cnt, 3);
        check("cnt_branch", branch_taken_cnt, 1);
        @(negedge clk);
        force dut.bubble_cnt = '1;
        #1 release dut.bubble_cnt;
        drive(1, 0, 1, 0, 3'b000, 2'b00, 0, 0, 0, 0); step();
        check("cnt_wrap", bubble_cnt, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/buffer_ex_mem.md
Name: buffer_ex_mem

Overview:
- EX/MEM pipeline register, directly downstream of the ID/EX buffer.
- Captures the EX-stage results: ALU result, branch target, zero flag, store data and destination register.
- Also carries forward the M and WB control bundles produced by ID/EX.
- Adds stall (hold), flush (bubble insertion) and a valid bit. Drives the MEM stage, the MEM/WB buffer and the PC-source select.

Parameters:
- DATA_W, 32, width of the ALU result, branch target and store data.
- REG_W, 5, width of the register-file index.
- CNT_W, 32, width of the performance counters (optional feature only).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  the EX stage holds a real instruction this cycle.
- stall  in  1  hold all registered state.
- flush  in  1  replace the incoming instruction with a bubble.
- M  in  3  {MemWrite,MemRead,Branch} from ID/EX.
- WB  in  2  {MemtoReg,RegWrite} from ID/EX.
- add_result  in  DATA_W  branch target computed in EX.
- zero  in  1  ALU zero flag.
- alu_result  in  DATA_W  ALU output.
- rd2  in  DATA_W  store data.
- write_reg  in  REG_W  destination after the RegDst mux.
- valid_q  out  1  stage holds a real instruction.
- MemWrite_q, MemRead_q, Branch_q  out  1 each  M controls, gated by valid_q.
- MemtoReg_q, RegWrite_q  out  1 each  WB controls, gated by valid_q.
- branch_target_q  out  DATA_W  registered add_result.
- zero_q  out  1  registered zero.
- alu_result_q  out  DATA_W  registered ALU result (memory address / writeback value).
- write_data_q  out  DATA_W  registered rd2.
- write_reg_q  out  REG_W  registered write_reg.
- pcsrc  out  1  branch taken = valid_q & Branch_q & zero_q (combinational from registers only).

Behaviour:
- One clock, clk. Reset rst is asynchronous, active-high.
- Reset: every output and internal register goes to 0 immediately, without waiting for a clock edge. This includes valid_q and pcsrc.
- Reset deasserting between edges: the first capture happens on the next rising clk.
- Update priority at each rising clk: rst > flush > stall > load.
- Load (no flush, no stall):
  - All fields capture their inputs.
  - valid_q <= in_valid.
  - Latency is 1 cycle.
- Stall: every register holds, including valid_q and the data fields.
- Flush:
  - valid_q <= 0 and all five control registers <= 0.
  - Data registers (branch_target_q, zero_q, alu_result_q, write_data_q, write_reg_q) hold their previous values.
  - Flush overrides a simultaneous stall.
- in_valid=0 with no flush:
  - Data fields load normally.
  - valid_q <= 0 and all control registers <= 0 (bubble).
- Output gating: control outputs are 0 whenever valid_q=0, so a bubble never writes memory, the register file or the PC.
- pcsrc:
  - Pure AND of registered bits; no combinational path from inputs.
  - Asserts in the cycle after a taken branch is loaded.
  - Deasserts after the flush that follows it.
- Widths: no arithmetic in this block; all fields are stored verbatim at full width.
- Simultaneous flush and rst: rst wins.
- Stall held for N cycles: outputs are constant for N cycles.

Optional Feature:
- Macro: EXMEM_PERF_CNT_EN.
- When defined, two extra outputs are added, both CNT_W wide, both reset to 0:
  - bubble_cnt: increments on every non-stalled clk edge that loads valid_q=0 (flush or in_valid=0).
  - branch_taken_cnt: increments on every clk edge where pcsrc=1 and stall=0.
- Both counters wrap from all-ones to 0 silently.
- Both counters hold during stall.
- When the macro is undefined:
  - Neither port nor counter exists.
  - All other behaviour is identical.

Test Plan:
1. Reset mid-operation: load alu_result=0x0000_00A4, WB=2'b11; assert rst asynchronously between edges -> all outputs 0 immediately, with no clk edge needed.
2. Normal load: in_valid=1, M=3'b010, WB=2'b11, alu_result=0x1000_0008, write_reg=5'd9, rd2=0xDEAD_BEEF -> one edge later MemRead_q=1, MemtoReg_q=1, RegWrite_q=1, alu_result_q=0x1000_0008, write_reg_q=9, write_data_q=0xDEAD_BEEF, valid_q=1.
3. Taken branch: M=3'b001, zero=1, add_result=0x0040_0020 -> next cycle pcsrc=1, branch_target_q=0x0040_0020. Then flush=1 -> next cycle pcsrc=0, valid_q=0, branch_target_q still 0x0040_0020.
4. Stall versus flush: load WB=2'b01; stall=1 for 3 cycles with changing inputs -> outputs unchanged all 3 cycles. Then stall=1 and flush=1 together -> valid_q=0 and RegWrite_q=0 (flush wins).
5. Bubble via in_valid=0: M=3'b100, WB=2'b01, alu_result=0x44 -> alu_result_q=0x44, MemWrite_q=0, RegWrite_q=0, valid_q=0.
6. With EXMEM_PERF_CNT_EN: 2 flushes, 1 in_valid=0 cycle and 1 taken branch, plus one stalled cycle with in_valid=0 -> bubble_cnt=3, branch_taken_cnt=1. Preload a counter to all-ones (force) -> it wraps to 0.
